serial_add_unit: RTL and testbench



---
 rtl/serial_add_unit.sv | 151 +++++++++++++++
 tb/tb_serial_add_unit.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial adder. It adds two WIDTH-bit operands LSB-first,
// one bit per clock, using a full adder made of two half-adder slices and a
// single carry flop.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   upstream operand pair is valid
//   in_ready   unit can accept an operand pair (IDLE only)
//   a, b       operands, sampled on the accept edge
//   out_valid  sum/carry hold a fresh result (DONE only)
//   out_ready  downstream takes the result
//   sum        registered WIDTH-bit result, holds the last delivered value
//   carry      registered carry-out of the MSB
//   busy       serial addition in progress (RUN only)
module serial_add_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic deliver;
    logic last_bit;

    logic ha0_s;
    logic ha0_c;
    logic ha1_s;
    logic ha1_c;
    logic carry_nxt;

    logic in_ready_nxt;
    logic busy_nxt;
    logic out_valid_nxt;

    assign accept   = (state == IDLE) && in_valid;
    assign deliver  = (state == DONE) && out_ready;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Full adder for the current bit: two chained half adders plus carry OR.
    assign ha0_s     = a_sh[0] ^ b_sh[0];
    assign ha0_c     = a_sh[0] & b_sh[0];
    assign ha1_s     = ha0_s ^ c;
    assign ha1_c     = ha0_s & c;
    assign carry_nxt = ha0_c | ha1_c;

    // State register; handshake/status flags are registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)   state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (deliver)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Flag decode from the upcoming state so the flags line up with it.
    always_comb begin
        in_ready_nxt  = 1'b0;
        busy_nxt      = 1'b0;
        out_valid_nxt = 1'b0;
        unique case (state_nxt)
            IDLE:    in_ready_nxt  = 1'b1;
            RUN:     busy_nxt      = 1'b1;
            DONE:    out_valid_nxt = 1'b1;
            default: in_ready_nxt  = 1'b1;
        endcase
    end

    // Serial datapath. The result registers are loaded only on the final RUN
    // edge, so they keep the last delivered result outside DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            carry  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= {ha1_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= carry_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum   <= {ha1_s, sum_sh[WIDTH-1:1]};
                        carry <= carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed self-checking bench for serial_add_unit (WIDTH=8 and WIDTH=2 instances).
module tb_serial_add_unit;

    logic       clk;
    logic       rst;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] sum8;
    logic       carry8;
    logic       busy8;

    logic       in_valid2;
    logic       in_ready2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       out_valid2;
    logic       out_ready2;
    logic [1:0] sum2;
    logic       carry2;
    logic       busy2;

    integer checks;
    integer failures;

    integer cyc;
    integer acc_cnt;
    integer last_acc;
    integer prev_acc;

    serial_add_unit #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .carry     (carry8),
        .busy      (busy8)
    );

    serial_add_unit #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .carry     (carry2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept-edge monitor for the WIDTH=8 instance.
    initial begin
        cyc      = 0;
        acc_cnt  = 0;
        last_acc = 0;
        prev_acc = 0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid8 && in_ready8) begin
            acc_cnt  <= acc_cnt + 1;
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
    end

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           output logic [7:0] s, output logic cy, output bit to);
        int n;
        to = 1'b0;
        s  = '0;
        cy = 1'b0;
        @(negedge clk);
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) begin
            in_valid8 = 1'b0;
            to = 1'b1;
            return;
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid8) begin
            to = 1'b1;
            return;
        end
        s  = sum8;
        cy = carry8;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic run_op2(input logic [1:0] av, input logic [1:0] bv,
                           output logic [1:0] s, output logic cy, output bit to);
        int n;
        to = 1'b0;
        s  = '0;
        cy = 1'b0;
        @(negedge clk);
        a2 = av;
        b2 = bv;
        in_valid2 = 1'b1;
        n = 0;
        while (!in_ready2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready2) begin
            in_valid2 = 1'b0;
            to = 1'b1;
            return;
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid2) begin
            to = 1'b1;
            return;
        end
        s  = sum2;
        cy = carry2;
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready8, out_valid8, busy8, carry8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_w8: rdy/vld/busy/cy/sum got %b%b%b%b %h want 1000 00",
                     in_ready8, out_valid8, busy8, carry8, sum8);
        end
        checks++;
        if ({in_ready2, out_valid2, busy2, carry2, sum2} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL reset_w2: rdy/vld/busy/cy/sum got %b%b%b%b %b want 1000 00",
                     in_ready2, out_valid2, busy2, carry2, sum2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Cycle-accurate FF+01: busy for edges 1..8, valid after edge 8, IDLE after edge 9.
    task automatic test_timing();
        @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL timing_ready_before: got %b want 1", in_ready8);
        end
        a8 = 8'hFF;
        b8 = 8'h01;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({busy8, out_valid8, in_ready8} !== {1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL timing_run_%0d: busy/vld/rdy got %b%b%b want 100",
                         k, busy8, out_valid8, in_ready8);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy8, out_valid8, in_ready8, carry8, sum8} !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL timing_done: busy/vld/rdy/cy/sum got %b%b%b%b %h want 0101 00",
                     busy8, out_valid8, in_ready8, carry8, sum8);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checks++;
        if ({busy8, out_valid8, in_ready8, carry8, sum8} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL timing_idle: busy/vld/rdy/cy/sum got %b%b%b%b %h want 0011 00",
                     busy8, out_valid8, in_ready8, carry8, sum8);
        end
    endtask

    task automatic test_independent();
        logic [7:0] s;
        logic       cy;
        bit         to;
        run_op8(8'h5A, 8'hA5, s, cy, to);
        checks++;
        if (to || {cy, s} !== 9'h0FF) begin
            failures++;
            $display("FAIL add_5A_A5: timeout=%0d got %b/%h want 0/ff", to, cy, s);
        end
        run_op8(8'h80, 8'h80, s, cy, to);
        checks++;
        if (to || {cy, s} !== 9'h100) begin
            failures++;
            $display("FAIL add_80_80: timeout=%0d got %b/%h want 1/00", to, cy, s);
        end
        run_op8(8'h00, 8'h00, s, cy, to);
        checks++;
        if (to || {cy, s} !== 9'h000) begin
            failures++;
            $display("FAIL add_00_00_no_leak: timeout=%0d got %b/%h want 0/00", to, cy, s);
        end
    endtask

    task automatic test_width2();
        logic [1:0] av [3];
        logic [1:0] bv [3];
        logic [2:0] ex [3];
        logic [1:0] s;
        logic       cy;
        bit         to;
        av[0] = 2'b00; bv[0] = 2'b11; ex[0] = 3'b011;
        av[1] = 2'b01; bv[1] = 2'b11; ex[1] = 3'b100;
        av[2] = 2'b01; bv[2] = 2'b10; ex[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            run_op2(av[i], bv[i], s, cy, to);
            checks++;
            if (to || {cy, s} !== ex[i]) begin
                failures++;
                $display("FAIL w2_pair_%0d: timeout=%0d got %b/%b want %b/%b",
                         i, to, cy, s, ex[i][2], ex[i][1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a8 = 8'h12;
        b8 = 8'h34;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({out_valid8, in_ready8, carry8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h46}) begin
                failures++;
                $display("FAIL bp_hold_%0d: vld/rdy/cy/sum got %b%b%b %h want 100 46",
                         k, out_valid8, in_ready8, carry8, sum8);
            end
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checks++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: vld/rdy got %b%b want 01", out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s;
        logic       cy;
        bit         to;
        @(negedge clk);
        a8 = 8'h0F;
        b8 = 8'h0F;
        in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: got %b want 1", busy8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready8, out_valid8, busy8, carry8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL midrun_reset: rdy/vld/busy/cy/sum got %b%b%b%b %h want 1000 00",
                     in_ready8, out_valid8, busy8, carry8, sum8);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op8(8'h0F, 8'h0F, s, cy, to);
        checks++;
        if (to || {cy, s} !== 9'h01E) begin
            failures++;
            $display("FAIL midrun_after: timeout=%0d got %b/%h want 0/1e", to, cy, s);
        end
    endtask

    task automatic test_churn();
        integer acc0;
        acc0 = acc_cnt;
        @(negedge clk);
        a8 = 8'h3C;
        b8 = 8'h99;
        in_valid8 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            in_valid8 = 1'($urandom_range(0, 1));
        end
        in_valid8 = 1'b0;
        checks++;
        if ({out_valid8, carry8, sum8} !== {1'b1, 1'b0, 8'hD5}) begin
            failures++;
            $display("FAIL churn_result: vld/cy/sum got %b%b %h want 10 d5",
                     out_valid8, carry8, sum8);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checks++;
        if (acc_cnt - acc0 !== 1) begin
            failures++;
            $display("FAIL churn_accepts: got %0d want 1", acc_cnt - acc0);
        end
    endtask

    task automatic test_back_to_back();
        integer acc0;
        int     n;
        acc0 = acc_cnt;
        @(negedge clk);
        a8 = 8'h01;
        b8 = 8'h02;
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        repeat (25) @(negedge clk);
        in_valid8 = 1'b0;
        checks++;
        if (acc_cnt - acc0 !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 3", acc_cnt - acc0);
        end
        checks++;
        if (last_acc - prev_acc !== 10) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d want 10", last_acc - prev_acc);
        end
        n = 0;
        while ((busy8 || out_valid8) && n < 30) begin
            @(negedge clk);
            n++;
        end
        out_ready8 = 1'b0;
        checks++;
        if ({busy8, out_valid8, in_ready8, carry8, sum8} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h03}) begin
            failures++;
            $display("FAIL b2b_drain: busy/vld/rdy/cy/sum got %b%b%b%b %h want 0010 03",
                     busy8, out_valid8, in_ready8, carry8, sum8);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        a8         = '0;
        b8         = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        a2         = '0;
        b2         = '0;

        test_reset();
        test_timing();
        test_independent();
        test_width2();
        test_backpressure();
        test_reset_mid_run();
        test_churn();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
